// File: rtl/skid_buffer_pkg.sv
// Shared definitions for the registered two-entry skid buffer.
//   state_e    : occupancy state; encodings equal the Count output values.
//   DATA_WIDTH : default datapath width.
package skid_buffer_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage : skid_buffer_pkg

// File: rtl/skid_buffer_reg.sv
// WIDTH-bit storage register with load enable; clears on reset.
//   clk, rst_n : clock, async active-low reset
//   en         : load d on the next rising edge
//   d, q       : data in, registered data out
module skid_buffer_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : skid_buffer_reg

// File: rtl/skid_buffer.sv
// Registered two-entry elastic buffer with valid/ready on both sides.
// In_Ready, Out_Valid, Count and Out_Data all come straight from flops,
// so no combinational path crosses the buffer in either direction.
//   Clock, Reset_n      : clock, async active-low reset
//   Flush               : synchronous discard of buffered words
//   In_Data/Valid/Ready : producer side
//   Out_Data/Valid/Ready: consumer side (Out_Data = head word)
//   Count               : words held (0..2)
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Flush,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [1:0]       Count
);

  state_e           state_q;
  state_e           state_d;
  logic             main_load;
  logic             skid_load;
  logic [WIDTH-1:0] main_next;
  logic [WIDTH-1:0] skid_q;
  logic             acc;
  logic             pop;

  assign acc = In_Valid & In_Ready;
  assign pop = Out_Valid & Out_Ready;

  // Next-state and register-load decode.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_next = In_Data;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d   = ONE;
          main_load = 1'b1;
        end
      end
      ONE: begin
        if (acc && pop) begin
          main_load = 1'b1;
        end else if (acc) begin
          state_d   = TWO;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d   = ONE;
          main_load = 1'b1;
          main_next = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything; loads are suppressed so discarded words never
    // reach Out_Data, which keeps its previous value.
    if (Flush) begin
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // State and flow-control flops; handshake outputs decoded from next state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= EMPTY;
      In_Ready  <= 1'b1;
      Out_Valid <= 1'b0;
      Count     <= 2'd0;
    end else begin
      state_q   <= state_d;
      In_Ready  <= (state_d != TWO);
      Out_Valid <= (state_d != EMPTY);
      Count     <= 2'(state_d);
    end
  end

  skid_buffer_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (Clock),
    .rst_n (Reset_n),
    .en    (main_load),
    .d     (main_next),
    .q     (Out_Data)
  );

  skid_buffer_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (Clock),
    .rst_n (Reset_n),
    .en    (skid_load),
    .d     (In_Data),
    .q     (skid_q)
  );

endmodule : skid_buffer
